// File: rtl/music_note_sequencer_pkg.sv
// music_pkg: shared constants, ROM entry field positions and FSM state type for the note sequencer.
package music_pkg;
  localparam int NOTE_W = 6;
  localparam logic [NOTE_W-1:0] REST_CODE = 6'd63;
  localparam logic [NOTE_W-1:0] MAX_NOTE = 6'd59;
  localparam int END_DUR = 0;
  localparam int NOTE_LSB = 0;
  localparam int DUR_LSB = NOTE_W;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;
endpackage

// File: rtl/music_note_sequencer_if.sv
// music_note_sequencer_if: control inputs and note/status outputs of the sequencer.
interface music_note_sequencer_if;
  logic i_start;
  logic i_stop;
  logic i_loop_en;
  logic [5:0] o_full_note;
  logic o_note_valid;
  logic o_busy;
  logic o_done;
  modport master(output i_start, i_stop, i_loop_en, input o_full_note, o_note_valid, o_busy, o_done);
  modport slave(input i_start, i_stop, i_loop_en, output o_full_note, o_note_valid, o_busy, o_done);
endinterface

// File: rtl/music_note_sequencer_rom.sv
// music_song_rom: synchronous song ROM; built-in melody table unless USE_SONG selects the SONG image.
module music_song_rom
  import music_pkg::*;
#(
  parameter int ROM_DEPTH = 32,
  parameter int DUR_W = 4,
  parameter bit USE_SONG = 1'b0,
  parameter logic [ROM_DEPTH*(DUR_W+NOTE_W)-1:0] SONG = '0
) (
  input  logic clk,
  input  logic [$clog2(ROM_DEPTH)-1:0] addr,
  output logic [DUR_W+NOTE_W-1:0] q
);
  localparam int EW = DUR_W + NOTE_W;
  function automatic logic [EW-1:0] table_entry(input int a);
    case (a)
      0: return {DUR_W'(4), 6'd0};
      1: return {DUR_W'(2), 6'd4};
      2: return {DUR_W'(2), 6'd7};
      3: return {DUR_W'(8), 6'd12};
      default: return '0;
    endcase
  endfunction
  always_ff @(posedge clk)
    q <= USE_SONG ? SONG[int'(addr)*EW +: EW] : table_entry(int'(addr));
endmodule

// File: rtl/music_note_sequencer.sv
// music_note_sequencer: steps through the song ROM, presenting each note with a gate for dur tempo ticks.
// Define SEQ_GAP_EN to insert a one-tick silent GAP after every note.
module music_note_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV = 1562500,
  parameter int ROM_DEPTH = 32,
  parameter int DUR_W = 4,
  parameter bit USE_SONG = 1'b0,
  parameter logic [ROM_DEPTH*(DUR_W+NOTE_W)-1:0] SONG = '0
) (
  input logic clk,
  input logic rst,
  music_note_sequencer_if.slave bus
);
  localparam int AW = $clog2(ROM_DEPTH);
  localparam int EW = DUR_W + NOTE_W;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t r_state, w_nstate;
  logic [AW:0] r_addr, w_naddr;
  logic [TW-1:0] r_tick, w_ntick;
  logic [DUR_W-1:0] r_dur, w_ndur;
  logic [NOTE_W-1:0] r_note, w_nnote;
  logic r_valid, w_nvalid, r_done, w_ndone;
  logic [EW-1:0] w_entry;
  logic [DUR_W-1:0] w_ent_dur;
  logic [NOTE_W-1:0] w_ent_note;
  logic w_end, w_wrap, w_last;
  music_song_rom #(.ROM_DEPTH(ROM_DEPTH), .DUR_W(DUR_W), .USE_SONG(USE_SONG), .SONG(SONG)) u_rom (
    .clk(clk),
    .addr(r_addr[AW-1:0]),
    .q(w_entry)
  );
  assign w_ent_dur = w_entry[DUR_LSB +: DUR_W];
  assign w_ent_note = w_entry[NOTE_LSB +: NOTE_W];
  // the extra address bit marks running off the end of the ROM, which reads as an end marker
  assign w_end = w_ent_dur == DUR_W'(END_DUR) || r_addr >= (AW+1)'(ROM_DEPTH);
  assign w_wrap = r_tick == TW'(TICK_DIV - 1);
  assign w_last = w_wrap && r_dur == DUR_W'(1);
  always_comb begin
    w_nstate = r_state;
    w_naddr = r_addr;
    w_ntick = r_tick;
    w_ndur = r_dur;
    w_nnote = r_note;
    w_nvalid = r_valid;
    w_ndone = 1'b0;
    case (r_state)
      IDLE: if (bus.i_start) begin
        w_nstate = FETCH;
        w_naddr = '0;
      end
      FETCH: w_nstate = LOAD;
      LOAD: if (!w_end) begin
        w_nnote = w_ent_note;
        w_nvalid = w_ent_note <= MAX_NOTE;
        w_ndur = w_ent_dur;
        w_ntick = '0;
        w_nstate = PLAY;
      end else if (bus.i_loop_en && r_addr != '0) begin
        w_nstate = FETCH;
        w_naddr = '0;
      end else begin
        w_nstate = IDLE;
        w_ndone = 1'b1;
        w_nnote = REST_CODE;
        w_nvalid = 1'b0;
      end
      PLAY: begin
        w_ntick = w_wrap ? '0 : r_tick + 1'b1;
        w_ndur = w_wrap ? r_dur - 1'b1 : r_dur;
        if (w_last) begin
          w_naddr = r_addr + 1'b1;
`ifdef SEQ_GAP_EN
          w_nstate = GAP;
`else
          w_nstate = FETCH;
`endif
        end
      end
`ifdef SEQ_GAP_EN
      GAP: begin
        w_ntick = w_wrap ? '0 : r_tick + 1'b1;
        if (w_wrap) w_nstate = FETCH;
      end
`endif
      default: w_nstate = IDLE;
    endcase
    if (bus.i_stop) begin
      w_nstate = IDLE;
      w_nnote = REST_CODE;
      w_nvalid = 1'b0;
      w_ndone = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_tick <= '0;
      r_dur <= '0;
      r_note <= REST_CODE;
      r_valid <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_addr <= w_naddr;
      r_tick <= w_ntick;
      r_dur <= w_ndur;
      r_note <= w_nnote;
      r_valid <= w_nvalid;
      r_done <= w_ndone;
    end
  end
  assign bus.o_full_note = r_note;
`ifdef SEQ_GAP_EN
  assign bus.o_note_valid = r_valid && r_state != GAP;
`else
  assign bus.o_note_valid = r_valid;
`endif
  assign bus.o_busy = r_state != IDLE;
  assign bus.o_done = r_done;
endmodule

// File: tb/tb_music_note_sequencer.sv
// tb_music_note_sequencer: three sequencers with different songs against a per-cycle expected-output timeline.
module tb_music_note_sequencer;
  localparam int TD = 4;
  localparam int LEN = 120;
  localparam logic [8:0] IDLE_OBS = {6'd63, 3'b000};
  localparam logic [319:0] SONG_A = 320'({10'd0, {4'd1, 6'd5}, {4'd1, 6'd61}, {4'd1, 6'd63}, {4'd1, 6'd3}, {4'd2, 6'd0}});
  localparam logic [39:0] SONG_B = {{4'd1, 6'd59}, {4'd1, 6'd63}, {4'd2, 6'd12}, {4'd1, 6'd7}};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [3];
  logic stop = 1'b0;
  logic loop_en = 1'b0;
  logic [8:0] got [3];
  logic [319:0] song [3];
  int depth [3];
  logic [8:0] exp_q [3][$];
  int n_checks = 0;
  int n_errors = 0;
  music_note_sequencer_if if_a ();
  music_note_sequencer_if if_b ();
  music_note_sequencer_if if_c ();
  assign if_a.i_start = start[0];
  assign if_b.i_start = start[1];
  assign if_c.i_start = start[2];
  assign {if_a.i_stop, if_b.i_stop, if_c.i_stop} = {3{stop}};
  assign {if_a.i_loop_en, if_b.i_loop_en, if_c.i_loop_en} = {3{loop_en}};
  assign got[0] = {if_a.o_full_note, if_a.o_note_valid, if_a.o_busy, if_a.o_done};
  assign got[1] = {if_b.o_full_note, if_b.o_note_valid, if_b.o_busy, if_b.o_done};
  assign got[2] = {if_c.o_full_note, if_c.o_note_valid, if_c.o_busy, if_c.o_done};
  music_note_sequencer #(.TICK_DIV(TD), .ROM_DEPTH(32), .USE_SONG(1'b1), .SONG(SONG_A)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  music_note_sequencer #(.TICK_DIV(TD), .ROM_DEPTH(4), .USE_SONG(1'b1), .SONG(SONG_B)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  music_note_sequencer #(.TICK_DIV(TD), .ROM_DEPTH(32), .USE_SONG(1'b1), .SONG('0)) u_c (.clk(clk), .rst(rst), .bus(if_c));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask
  // timeline entry j is {full_note, note_valid, busy, done} just after the j-th edge following the start edge
  task automatic build(input int d, input int loop_until, input int stop_at);
    logic [5:0] note;
    logic v;
    logic [9:0] e;
    int idx;
    int dur;
    note = 6'd63;
    v = 1'b0;
    idx = 0;
    exp_q[d].delete();
    repeat (2) exp_q[d].push_back({note, v, 2'b10});
    while (exp_q[d].size() < LEN) begin
      e = idx < depth[d] ? song[d][idx*10 +: 10] : 10'd0;
      dur = int'(e[9:6]);
      if (dur == 0) begin
        if (exp_q[d].size() < loop_until && idx != 0) begin
          idx = 0;
          repeat (2) exp_q[d].push_back({note, v, 2'b10});
        end else begin
          exp_q[d].push_back({6'd63, 3'b001});
          while (exp_q[d].size() < LEN) exp_q[d].push_back(IDLE_OBS);
        end
      end else begin
        note = e[5:0];
        v = note < 6'd60;
        repeat (dur * TD) exp_q[d].push_back({note, v, 2'b10});
`ifdef SEQ_GAP_EN
        repeat (TD) exp_q[d].push_back({note, 3'b010});
`endif
        repeat (2) exp_q[d].push_back({note, v, 2'b10});
        idx++;
      end
    end
    while (exp_q[d].size() > LEN) void'(exp_q[d].pop_back());
    if (stop_at < LEN && exp_q[d][stop_at-1][1])
      for (int j = stop_at; j < LEN; j++) exp_q[d][j] = IDLE_OBS;
  endtask
  task automatic run(input int loop_until, input int stop_at, input int es);
    @(negedge clk);
    rst = 1'b1;
    stop = 1'b0;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("reset dut%0d", d), 32'(got[d]), 32'(IDLE_OBS));
    @(negedge clk);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    for (int d = 0; d < 3; d++) build(d, loop_until, stop_at);
    for (int j = 0; j < LEN; j++) begin
      for (int d = 0; d < 3; d++) start[d] = j == 0 || (es > 0 && j == es && exp_q[d][j-1][1]);
      stop = j == stop_at;
      loop_en = j < loop_until;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check($sformatf("dut%0d cyc%0d", d, j), 32'(got[d]), 32'(exp_q[d][j]));
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    stop = 1'b0;
  endtask
  initial begin
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    song[0] = SONG_A;
    song[1] = 320'(SONG_B);
    song[2] = '0;
    depth[0] = 32;
    depth[1] = 4;
    depth[2] = 32;
    run(0, LEN, 0);
    run(LEN, LEN, 0);
    run(50, LEN, 0);
    run(0, 15, 0);
    run(LEN, LEN, 7);
    run(0, 1, 0);
    for (int i = 0; i < 10; i++)
      run($urandom_range(0, LEN), $urandom_range(0, 1) ? $urandom_range(1, LEN - 1) : LEN, $urandom_range(0, 40));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/music_note_sequencer.md
Name: music_note_sequencer

Overview:
- Upstream stage of the tone generator: steps through a melody stored in a small ROM.
- Presents one 6-bit full-note code (octave*12 + semitone, 0 = lowest A) at a time, with a gate, for a programmed number of tempo ticks.
- Its full_note / note_valid outputs drive the note-to-divider tone stage directly.

Parameters:
- TICK_DIV, 1562500, clk cycles per tempo tick (25 MHz / 16 Hz); bench uses 4.
- ROM_DEPTH, 32, number of song entries; address width is clog2(ROM_DEPTH).
- DUR_W, 4, duration field width in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begin playback at entry 0 (ignored while busy).
- stop  in  1  abort playback; dominates start.
- loop_en  in  1  sampled at end marker; 1 = restart from entry 0.
- full_note  out  6  current note code; 63 = rest.
- note_valid  out  1  gate: 1 while a non-rest note is sounding.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the song ends without looping.

Behaviour:
- ROM entry format: {dur[DUR_W-1:0], note[5:0]}.
  - dur == 0 is the end marker.
  - note == 63 is a rest; codes 60..62 are illegal and are played as a rest.
- ROM read is synchronous (1 cycle).
- Reset values: full_note = 63, note_valid = 0, busy = 0, done = 0, addr = 0, state = IDLE, tick and duration counters = 0.
- States:
  - IDLE: on start -> FETCH, addr = 0.
  - FETCH: ROM address presented -> LOAD.
  - LOAD: rom_q is valid; decode the entry.
    - End marker: if loop_en and addr != 0, go to FETCH with addr = 0.
    - Otherwise pulse done, set full_note = 63 and note_valid = 0, go to IDLE.
    - Entry 0 being the end marker always ends playback, so a looping empty song cannot spin forever.
    - Note entry: register full_note = note, note_valid = (note < 60), dur_cnt = dur, tick_cnt = 0 -> PLAY.
  - PLAY: tick_cnt counts 0..TICK_DIV-1 and wraps; dur_cnt decrements on each wrap.
    - When dur_cnt reaches 0, increment addr -> FETCH (GAP when SEQ_GAP_EN is defined).
    - If addr was ROM_DEPTH-1, the next entry is treated as the end marker (no address wrap).
- Timing:
  - start sampled at edge k -> outputs show the first note after edge k+2 (latency 2).
  - Each note occupies exactly dur*TICK_DIV cycles in PLAY.
  - During FETCH/LOAD between notes, full_note and note_valid hold the previous values (2-cycle extension, no click).
- Stop: when sampled high in any non-IDLE state, the next state is IDLE with full_note = 63 and note_valid = 0. No done pulse. stop has priority over the LOAD decision and over start.
- start while busy: ignored. start and stop in the same cycle in IDLE: remain IDLE.
- rst mid-playback: all registers return to reset values on that edge.

Optional Feature:
- Macro: SEQ_GAP_EN.
- Defined:
  - PLAY exits to a GAP state lasting exactly TICK_DIV cycles, with note_valid = 0 and full_note held, then goes to FETCH. Gives articulation between repeated notes.
  - GAP also follows the last note before the end marker.
  - stop during GAP -> IDLE.
- Not defined: GAP state is absent; PLAY goes directly to FETCH.

Decomposition:
- Package music_pkg:
  - NOTE_W = 6, REST_CODE = 6'd63, MAX_NOTE = 59, END_DUR = 0.
  - Entry-field slice constants.
  - State enum {IDLE, FETCH, LOAD, PLAY, GAP}.
- Sub-module music_song_rom: case-based constant table, registered output, ports clk, addr, q. Benches substitute their own contents.

Test Plan (TICK_DIV = 4, SEQ_GAP_EN undefined unless stated):
- ROM {n0 d2, n3 d1, END}, start at cycle 10:
  - full_note = 0 and note_valid = 1 from cycle 12 to 21.
  - full_note = 3 from cycle 22 to 27.
  - done pulses at cycle 28; busy falls on the same edge; full_note = 63.
- ROM {n63 d1, n5 d1, END}:
  - note_valid = 0 for the first 6 cycles after latency.
  - Then note_valid = 1 with full_note = 5 for 4 cycles; done follows.
- loop_en = 1, ROM {n7 d1, END}:
  - note 7 repeats indefinitely with no done pulse.
  - Drop loop_en -> done on the next end marker.
  - ROM {END} with loop_en = 1 -> done 2 cycles after start.
- stop asserted mid-PLAY of n10 d3:
  - next cycle: IDLE, note_valid = 0, full_note = 63, busy = 0, no done pulse.
- start pulsed again while busy: no restart and addr unchanged. rst asserted mid-note: all outputs at reset values on the next edge.
- SEQ_GAP_EN defined, ROM {n2 d1, n2 d1, END}: note_valid low for exactly 4 cycles between the two notes.
